// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 responder: register map, command bits,
// serial FSM states and calendar helpers.
package ds1302_pkg;

  localparam logic [4:0] ADDR_SEC   = 5'd0;
  localparam logic [4:0] ADDR_MIN   = 5'd1;
  localparam logic [4:0] ADDR_HOUR  = 5'd2;
  localparam logic [4:0] ADDR_DATE  = 5'd3;
  localparam logic [4:0] ADDR_MONTH = 5'd4;
  localparam logic [4:0] ADDR_DAY   = 5'd5;
  localparam logic [4:0] ADDR_YEAR  = 5'd6;
  localparam logic [4:0] ADDR_CTRL  = 5'd7;
  localparam logic [4:0] ADDR_BURST = 5'd31;

  localparam int unsigned CMD_RD    = 0;
  localparam int unsigned CMD_RAM   = 6;
  localparam int unsigned CMD_VALID = 7;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, WAIT_CE_LOW} state_t;

  // Leap test straight on the BCD digits: tens even -> ones 0/4/8, tens odd -> ones 2/6.
  function automatic logic is_leap_bcd(input logic [7:0] year);
    if (!year[4]) return (year[3:0] == 4'd0) || (year[3:0] == 4'd4) || (year[3:0] == 4'd8);
    return (year[3:0] == 4'd2) || (year[3:0] == 4'd6);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return is_leap_bcd(year) ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/ds1302_rtc_core.sv
// Timekeeping register file: 1 s prescaler, BCD calendar ripple counting and
// a single write port; a host write always wins over a same-cycle tick.
module ds1302_rtc_core import ds1302_pkg::*; #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] data,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [7:0] year,
  output logic [7:0] ctrl
);

  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] cnt;
  logic        tick;
  logic [8:0]  s_n, m_n, h_n, d_n, dy_n, mo_n, y_n;

  // {carry, next}; out-of-range values wrap and any ones digit >= 9 carries.
  function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] top,
                                          input logic [7:0] first);
    if (v >= top) return {1'b1, first};
    if (v[3:0] >= 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick = !sec[7] && (cnt == LAST);

  always_comb begin
    s_n  = bcd_step({1'b0, sec[6:0]}, 8'h59, 8'h00);
    m_n  = bcd_step(min, 8'h59, 8'h00);
    h_n  = bcd_step({1'b0, hour[6:0]}, 8'h23, 8'h00);
    d_n  = bcd_step(date, days_in_month(month, year), 8'h01);
    dy_n = bcd_step(day, 8'h07, 8'h01);
    mo_n = bcd_step(month, 8'h12, 8'h01);
    y_n  = bcd_step(year, 8'h99, 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sec   <= 8'h00;
      min   <= 8'h00;
      hour  <= 8'h00;
      date  <= 8'h01;
      month <= 8'h01;
      day   <= 8'h01;
      year  <= 8'h00;
      ctrl  <= 8'h00;
    end else begin
      if (sec[7] || cnt == LAST) cnt <= '0;
      else                       cnt <= cnt + 32'd1;

      if (we) begin
        case (addr)
          ADDR_SEC[2:0]:   sec   <= data;
          ADDR_MIN[2:0]:   min   <= data;
          ADDR_HOUR[2:0]:  hour  <= data;
          ADDR_DATE[2:0]:  date  <= data;
          ADDR_MONTH[2:0]: month <= data;
          ADDR_DAY[2:0]:   day   <= data;
          ADDR_YEAR[2:0]:  year  <= data;
          ADDR_CTRL[2:0]:  ctrl  <= {data[7], 7'd0};
        endcase
      end else if (tick) begin
        sec <= s_n[7:0];
        if (s_n[8]) begin
          min <= m_n[7:0];
          if (m_n[8]) begin
            hour <= h_n[7:0] | (hour & 8'h80);
            if (h_n[8]) begin
              date <= d_n[7:0];
              day  <= dy_n[7:0];
              if (d_n[8]) begin
                month <= mo_n[7:0];
                if (mo_n[8]) year <= y_n[7:0];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/ds1302_responder.sv
// DS1302 3-wire slave: synchronises CE/SCLK/IO, decodes command bytes and
// serves single-byte and burst access to the RTC core.
module ds1302_responder import ds1302_pkg::*; #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic sclk,
  input  logic io_i,
  output logic io_o,
  output logic io_oe,
  output logic busy
);

  logic [1:0] ce_q, sclk_q, io_q;
  logic       ce_s, sclk_s, io_s, ce_d, sclk_d;
  logic       rise, fall, ce_rise;
  state_t     state;
  logic [2:0] bit_cnt, byte_idx;
  logic [6:0] shreg;
  logic [7:0] byte_in;
  logic [4:0] addr;
  logic       ram, burst;
  logic [7:0] snap [8];
  logic [7:0] regs [8];
  logic [2:0] wr_addr;
  logic       we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q   <= '0;
      sclk_q <= '0;
      io_q   <= '0;
      ce_d   <= 1'b0;
      sclk_d <= 1'b0;
    end else begin
      ce_q   <= {ce_q[0], ce};
      sclk_q <= {sclk_q[0], sclk};
      io_q   <= {io_q[0], io_i};
      ce_d   <= ce_s;
      sclk_d <= sclk_s;
    end
  end

  assign ce_s    = ce_q[1];
  assign sclk_s  = sclk_q[1];
  assign io_s    = io_q[1];
  assign rise    = sclk_s && !sclk_d;
  assign fall    = !sclk_s && sclk_d;
  assign ce_rise = ce_s && !ce_d;
  assign byte_in = {io_s, shreg};
  assign busy    = (state != IDLE);

  // Commit happens combinationally on the 8th data rising edge; WP spares control.
  always_comb begin
    wr_addr = burst ? byte_idx : addr[2:0];
    we = (state == WDATA) && ce_s && rise && (bit_cnt == 3'd7) && !ram &&
         (burst || addr < 5'd8) && (wr_addr == ADDR_CTRL[2:0] || !regs[7][7]);
  end

  ds1302_rtc_core #(.TICK_DIV(TICK_DIV)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (wr_addr),
    .data  (byte_in),
    .sec   (regs[0]),
    .min   (regs[1]),
    .hour  (regs[2]),
    .date  (regs[3]),
    .month (regs[4]),
    .day   (regs[5]),
    .year  (regs[6]),
    .ctrl  (regs[7])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      addr     <= '0;
      ram      <= 1'b0;
      burst    <= 1'b0;
      io_o     <= 1'b0;
      io_oe    <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) snap[i] <= '0;
    end else if (!ce_s) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_idx <= '0;
      io_oe    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ce_rise) begin
          state    <= CMD;
          bit_cnt  <= '0;
          byte_idx <= '0;
        end
        CMD: if (rise) begin
          shreg   <= byte_in[7:1];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            addr  <= byte_in[5:1];
            ram   <= byte_in[CMD_RAM];
            burst <= (byte_in[5:1] == ADDR_BURST);
            if (!byte_in[CMD_VALID]) state <= WAIT_CE_LOW;
            else if (byte_in[CMD_RD]) begin
              state <= RDATA;
              // Snapshot so a tick mid-read cannot tear the returned bytes.
              for (int unsigned i = 0; i < 8; i++)
                snap[i] <= (!byte_in[CMD_RAM] && (byte_in[5:1] == ADDR_BURST ||
                            (i == 0 && byte_in[5:1] < 5'd8)))
                           ? regs[(byte_in[5:1] == ADDR_BURST) ? 3'(i) : byte_in[3:1]] : '0;
            end else state <= WDATA;
          end
        end
        WDATA: if (rise) begin
          shreg   <= byte_in[7:1];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_idx <= byte_idx + 3'd1;
            if (!burst || byte_idx == 3'd7) state <= WAIT_CE_LOW;
          end
        end
        RDATA: if (fall) begin
          io_oe   <= 1'b1;
          io_o    <= snap[byte_idx][bit_cnt];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_idx <= byte_idx + 3'd1;
            if (!burst || byte_idx == 3'd7) state <= WAIT_CE_LOW;
          end
        end
        WAIT_CE_LOW: if (fall) io_oe <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
